wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter AGE_LIMIT, default 4, range 1..7: pipeline-write cycles a held long-latency result may wait before a drain stall is forced.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 RegWriteW  input  1  write-back-stage register write enable.
REQ-005 RdW  input  5  write-back-stage destination register.
REQ-006 ResultW  input  32  write-back-stage result (already selected ALU/load/PC+4).
REQ-007 lu_valid  input  1  long-latency unit (mul/div) result valid.
REQ-008 lu_rd  input  5  long-latency result destination.
REQ-009 lu_data  input  32  long-latency result value.
REQ-010 lu_ready  output  1  arbiter can accept a long-latency result this cycle.
REQ-011 rf_we  output  1  register-file write enable.
REQ-012 rf_rd  output  5  register-file write address.
REQ-013 rf_wd  output  32  register-file write data.
REQ-014 StallReq  output  1  registered request to hazard unit to bubble the M->W register.
REQ-015 pend_valid  output  1  a long-latency result is held, not yet written.
REQ-016 pend_rd  output  5  destination of held result, for hazard-unit RAW checks.

Function
REQ-017 Pipeline write ("pw") = RegWriteW && RdW != 0; pw always owns the port and is never delayed: rf_we=1, rf_rd=RdW, rf_wd=ResultW, combinational.
REQ-018 One-entry hold buffer; lu_ready = !buffer_valid, combinational; handshake completes when lu_valid && lu_ready.
REQ-019 States: IDLE (buffer empty), HOLD (buffer full, StallReq=0), DRAIN (buffer full, StallReq=1).
REQ-020 IDLE, handshake, no pw: result written same cycle (bypass, zero latency), stays IDLE, buffer not loaded.
REQ-021 IDLE, handshake, pw: result captured into buffer, age counter cleared, next state HOLD.
REQ-022 Handshake with lu_rd == 0: accepted, discarded, no write, no state change.
REQ-023 HOLD/DRAIN, no pw: buffer written (rf_we=1, rf_rd/rf_wd from buffer), buffer cleared, next state IDLE, StallReq 0 next cycle.
REQ-024 HOLD, pw with RdW != buffered rd: age counter +1; counter reaching AGE_LIMIT moves to DRAIN (StallReq=1 next cycle).
REQ-025 HOLD/DRAIN, pw with RdW == buffered rd: buffered entry dropped (younger write wins), next state IDLE, counter cleared.
REQ-026 DRAIN holds StallReq=1 until buffer written; hazard unit guarantees RegWriteW=0 from the cycle after StallReq rises.
REQ-027 Buffer full: no new acceptance (lu_ready=0); a result written from buffer frees the slot only from the next cycle.
REQ-028 pend_valid = buffer_valid; pend_rd = buffered rd when valid, else 0.
REQ-029 Age counter 3 bits, saturates at AGE_LIMIT, never wraps.

Reset
REQ-030 rst high: buffer invalid, state IDLE, counter 0, StallReq 0, pend_valid 0, pend_rd 0, lu_ready 1, rf_we forced 0 (rf_rd, rf_wd 0).
REQ-031 rst mid-operation: held result discarded without write; acceptance possible in first cycle after deassertion.

Configuration
REQ-032 Macro WBARB_AGE_LIMIT_EN defined: age counter, DRAIN state and StallReq per REQ-024/026.
REQ-033 Macro undefined: no counter, no DRAIN; StallReq tied 0; held result waits in HOLD until first non-pw cycle or REQ-025 drop.

Verification
REQ-034 Idle pipeline, lu_valid, lu_rd=5, lu_data=0x1234 -> same cycle rf_we=1, rf_rd=5, rf_wd=0x1234; pend_valid stays 0.
REQ-035 pw RdW=3 ResultW=0xA plus lu_valid lu_rd=7 data=0xB -> cycle0 writes x3=0xA; cycle1 pend_valid=1, pend_rd=7, lu_ready=0; first idle cycle writes x7=0xB.
REQ-036 Macro on, AGE_LIMIT=4, buffer held, pw every cycle RdW!=7 -> StallReq=1 after 4th pw cycle; next idle cycle writes buffer; StallReq=0 following cycle.
REQ-037 Buffer holds rd=9, pw RdW=9 ResultW=0x55 -> x9=0x55 written, pend_valid=0 next cycle, buffered value never written.
REQ-038 Buffer full, rst pulsed -> pend_valid=0, StallReq=0, lu_ready=1, no rf_we during reset; macro off: StallReq never 1 under 20 pw cycles.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the single register-file write port between the pipeline
//            write-back stage and a long-latency (mul/div) unit. Pipeline
//            writes always win. A long-latency result goes straight to the
//            port when the port is free. Otherwise it waits in a one-entry
//            hold buffer until the first cycle with no pipeline write.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            RegWriteW/RdW/ResultW - write-back stage write request
//            lu_valid/lu_rd/lu_data, lu_ready - long-latency result handshake
//            rf_we/rf_rd/rf_wd  - register-file write port
//            StallReq           - registered bubble request to the hazard unit
//            pend_valid/pend_rd - held-result status for RAW checks
// Config   : WBARB_AGE_LIMIT_EN - when defined, an age counter forces a drain
//            stall after AGE_LIMIT pipeline writes have delayed a held result.
//            When undefined, StallReq is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int AGE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic        StallReq,
  output logic        pend_valid,
  output logic [4:0]  pend_rd
);

  if (AGE_LIMIT < 1 || AGE_LIMIT > 7) begin : g_age_limit_range
    $error("wb_port_arbiter: AGE_LIMIT must be within 1..7");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        buf_valid_q, buf_valid_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;

  logic        pw;
  logic        hs_live;
  logic        release_buf;

`ifdef WBARB_AGE_LIMIT_EN
  localparam logic [2:0] AGE_LIM = 3'(AGE_LIMIT);
  logic [2:0]  age_q, age_d;
  logic        stall_q, stall_d;
`endif

  // Port ownership and handshake decode.
  always_comb begin
    pw       = RegWriteW && (RdW != 5'd0);
    lu_ready = !buf_valid_q;
    // A result for x0 is accepted but has nowhere to go, so it is ignored.
    hs_live  = lu_valid && lu_ready && (lu_rd != 5'd0);
    // The held entry leaves either by being written (no pw this cycle) or by
    // being overwritten by a younger pipeline write to the same register.
    release_buf = buf_valid_q && (!pw || (RdW == buf_rd_q));
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
`ifdef WBARB_AGE_LIMIT_EN
    age_d       = age_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hs_live && pw) begin
          state_d     = ST_HOLD;
          buf_valid_d = 1'b1;
          buf_rd_d    = lu_rd;
          buf_data_d  = lu_data;
`ifdef WBARB_AGE_LIMIT_EN
          age_d       = 3'd0;
`endif
        end
      end
      ST_HOLD, ST_DRAIN: begin
        if (release_buf) begin
          state_d     = ST_IDLE;
          buf_valid_d = 1'b0;
          buf_rd_d    = 5'd0;
`ifdef WBARB_AGE_LIMIT_EN
          age_d       = 3'd0;
`endif
        end
`ifdef WBARB_AGE_LIMIT_EN
        else begin
          // Saturating age: once at the limit the entry stays in DRAIN.
          if (age_q < AGE_LIM) begin
            age_d = age_q + 3'd1;
          end
          if (age_d >= AGE_LIM) begin
            state_d = ST_DRAIN;
          end
        end
`endif
      end
      default: begin
        state_d     = ST_IDLE;
        buf_valid_d = 1'b0;
        buf_rd_d    = 5'd0;
      end
    endcase
  end

`ifdef WBARB_AGE_LIMIT_EN
  always_comb begin
    stall_d = (state_d == ST_DRAIN);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      buf_valid_q <= 1'b0;
      buf_rd_q    <= 5'd0;
      buf_data_q  <= 32'd0;
`ifdef WBARB_AGE_LIMIT_EN
      age_q       <= 3'd0;
      stall_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
`ifdef WBARB_AGE_LIMIT_EN
      age_q       <= age_d;
      stall_q     <= stall_d;
`endif
    end
  end

  // Write-port mux. Reset blocks every write, including the combinational
  // pipeline and bypass paths that do not pass through a flop.
  always_comb begin
    rf_we = 1'b0;
    rf_rd = 5'd0;
    rf_wd = 32'd0;
    if (!rst) begin
      if (pw) begin
        rf_we = 1'b1;
        rf_rd = RdW;
        rf_wd = ResultW;
      end else if (buf_valid_q) begin
        rf_we = 1'b1;
        rf_rd = buf_rd_q;
        rf_wd = buf_data_q;
      end else if (hs_live) begin
        rf_we = 1'b1;
        rf_rd = lu_rd;
        rf_wd = lu_data;
      end
    end
  end

  always_comb begin
    pend_valid = buf_valid_q;
    pend_rd    = buf_valid_q ? buf_rd_q : 5'd0;
`ifdef WBARB_AGE_LIMIT_EN
    StallReq   = stall_q;
`else
    StallReq   = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Self-checking bench for wb_port_arbiter: directed scenarios for
//            bypass, capture, drop, x0 discard, ageing/no-stall and reset,
//            then a randomized run against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  localparam int AGE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        StallReq;
  logic        pend_valid;
  logic [4:0]  pend_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.AGE_LIMIT(AGE_LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .ResultW   (ResultW),
    .lu_valid  (lu_valid),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .lu_ready  (lu_ready),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .StallReq  (StallReq),
    .pend_valid(pend_valid),
    .pend_rd   (pend_rd)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                        input logic v, input logic [4:0] lrd, input logic [31:0] ld);
    RegWriteW = rw;
    RdW       = rd;
    ResultW   = res;
    lu_valid  = v;
    lu_rd     = lrd;
    lu_data   = ld;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_in(1'b1, 5'd4, 32'hDEAD, 1'b1, 5'd6, 32'h77);
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0h want 0", rf_we); end
    checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rf_rd got %0h want 0", rf_rd); end
    checks++; if (rf_wd !== 32'd0) begin errors++; $display("FAIL reset_rf_wd got %0h want 0", rf_wd); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_lu_ready got %0h want 1", lu_ready); end
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL reset_pend_valid got %0h want 0", pend_valid); end
    checks++; if (pend_rd !== 5'd0) begin errors++; $display("FAIL reset_pend_rd got %0h want 0", pend_rd); end
    checks++; if (StallReq !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h want 0", StallReq); end
    next_cycle();
    rst = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    next_cycle();
  endtask

  task automatic test_bypass;
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    @(negedge clk);
    checks++; if ({rf_we, rf_rd, rf_wd} !== {1'b1, 5'd5, 32'h1234})
      begin errors++; $display("FAIL bypass_write got we=%0h rd=%0d wd=%0h want we=1 rd=5 wd=1234", rf_we, rf_rd, rf_wd); end
    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL bypass_pend got %0h want 0", pend_valid); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL bypass_no_rewrite got %0h want 0", rf_we); end
    next_cycle();
  endtask

  task automatic test_capture;
    set_in(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
    @(negedge clk);
    checks++; if ({rf_we, rf_rd, rf_wd} !== {1'b1, 5'd3, 32'hA})
      begin errors++; $display("FAIL capture_pw got we=%0h rd=%0d wd=%0h want we=1 rd=3 wd=a", rf_we, rf_rd, rf_wd); end
    next_cycle();
    // Held entry must block a second offer and yield to another pipeline write.
    set_in(1'b1, 5'd2, 32'h22, 1'b1, 5'd8, 32'hC);
    @(negedge clk);
    checks++; if ({pend_valid, pend_rd, lu_ready} !== {1'b1, 5'd7, 1'b0})
      begin errors++; $display("FAIL capture_held got pv=%0h prd=%0d rdy=%0h want pv=1 prd=7 rdy=0", pend_valid, pend_rd, lu_ready); end
    checks++; if ({rf_we, rf_rd, rf_wd} !== {1'b1, 5'd2, 32'h22})
      begin errors++; $display("FAIL capture_pw2 got rd=%0d wd=%0h want rd=2 wd=22", rf_rd, rf_wd); end
    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hC);
    @(negedge clk);
    checks++; if ({rf_we, rf_rd, rf_wd} !== {1'b1, 5'd7, 32'hB})
      begin errors++; $display("FAIL capture_drain got we=%0h rd=%0d wd=%0h want we=1 rd=7 wd=b", rf_we, rf_rd, rf_wd); end
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL capture_slot_busy got %0h want 0", lu_ready); end
    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if ({pend_valid, pend_rd, lu_ready, rf_we} !== {1'b0, 5'd0, 1'b1, 1'b0})
      begin errors++; $display("FAIL capture_freed got pv=%0h prd=%0d rdy=%0h we=%0h want 0 0 1 0", pend_valid, pend_rd, lu_ready, rf_we); end
    next_cycle();
  endtask

  task automatic test_drop;
    set_in(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
    next_cycle();
    set_in(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if ({rf_we, rf_rd, rf_wd} !== {1'b1, 5'd9, 32'h55})
      begin errors++; $display("FAIL drop_younger got we=%0h rd=%0d wd=%0h want we=1 rd=9 wd=55", rf_we, rf_rd, rf_wd); end
    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if ({pend_valid, rf_we} !== 2'b00)
      begin errors++; $display("FAIL drop_discard got pv=%0h we=%0h want pv=0 we=0", pend_valid, rf_we); end
    next_cycle();
  endtask

  task automatic test_lu_rd_zero;
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hF);
    @(negedge clk);
    checks++; if ({rf_we, lu_ready} !== 2'b01)
      begin errors++; $display("FAIL x0_idle got we=%0h rdy=%0h want we=0 rdy=1", rf_we, lu_ready); end
    next_cycle();
    set_in(1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 32'hF);
    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if ({pend_valid, rf_we} !== 2'b00)
      begin errors++; $display("FAIL x0_with_pw got pv=%0h we=%0h want pv=0 we=0", pend_valid, rf_we); end
    next_cycle();
  endtask

`ifdef WBARB_AGE_LIMIT_EN
  task automatic test_aging;
    set_in(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h70);
    next_cycle();
    for (int i = 1; i <= AGE_LIMIT; i++) begin
      set_in(1'b1, 5'(10 + i), 32'(i), 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      checks++; if (StallReq !== 1'b0)
        begin errors++; $display("FAIL aging_early pw=%0d got %0h want 0", i, StallReq); end
      next_cycle();
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if ({StallReq, rf_we, rf_rd, rf_wd} !== {1'b1, 1'b1, 5'd7, 32'h70})
      begin errors++; $display("FAIL aging_drain got st=%0h we=%0h rd=%0d wd=%0h want 1 1 7 70", StallReq, rf_we, rf_rd, rf_wd); end
    next_cycle();
    @(negedge clk);
    checks++; if ({StallReq, pend_valid} !== 2'b00)
      begin errors++; $display("FAIL aging_release got st=%0h pv=%0h want 0 0", StallReq, pend_valid); end
    next_cycle();
  endtask
`else
  task automatic test_no_stall;
    int bad;
    bad = 0;
    set_in(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h70);
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 5'(10 + (i % 8)), 32'(i), 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      if (StallReq !== 1'b0 || pend_valid !== 1'b1) bad++;
      next_cycle();
    end
    checks++; if (bad != 0)
      begin errors++; $display("FAIL no_stall_hold got %0d bad cycles want 0", bad); end
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if ({StallReq, rf_we, rf_rd, rf_wd} !== {1'b0, 1'b1, 5'd7, 32'h70})
      begin errors++; $display("FAIL no_stall_drain got st=%0h we=%0h rd=%0d wd=%0h want 0 1 7 70", StallReq, rf_we, rf_rd, rf_wd); end
    next_cycle();
  endtask
`endif

  task automatic test_reset_mid;
    set_in(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC0);
    next_cycle();
    rst = 1'b1;
    set_in(1'b1, 5'd2, 32'h2, 1'b1, 5'd13, 32'hD0);
    @(negedge clk);
    checks++; if ({rf_we, pend_valid, StallReq, lu_ready} !== {1'b0, 1'b0, 1'b0, 1'b1})
      begin errors++; $display("FAIL rstmid_state got we=%0h pv=%0h st=%0h rdy=%0h want 0 0 0 1", rf_we, pend_valid, StallReq, lu_ready); end
    next_cycle();
    rst = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hD0);
    @(negedge clk);
    checks++; if ({rf_we, rf_rd, rf_wd} !== {1'b1, 5'd13, 32'hD0})
      begin errors++; $display("FAIL rstmid_accept got we=%0h rd=%0d wd=%0h want 1 13 d0", rf_we, rf_rd, rf_wd); end
    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++; if (rf_we !== 1'b0)
      begin errors++; $display("FAIL rstmid_no_stale got we=%0h want 0", rf_we); end
    next_cycle();
  endtask

  // Behavioural model: the arbiter is a one-slot queue whose occupant waits
  // while the pipeline keeps writing other registers.
  task automatic test_random;
    bit          m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_age;
    bit          m_stall;
    bit          rw, v, do_rst, pwm, take;
    logic [4:0]  rd, lrd;
    logic [31:0] res, ld;
    logic [45:0] exp_v, act_v;
    m_valid = 0; m_rd = 0; m_data = 0; m_age = 0; m_stall = 0;
    for (int n = 0; n < 500; n++) begin
      do_rst = ($urandom_range(0, 99) == 0);
      rw  = ($urandom_range(0, 3) != 0) && !m_stall;
      rd  = 5'($urandom_range(0, 7));
      res = $urandom;
      v   = ($urandom_range(0, 2) != 0);
      lrd = 5'($urandom_range(0, 7));
      ld  = $urandom;
      rst = do_rst;
      set_in(rw, rd, res, v, lrd, ld);
      if (do_rst) begin
        m_valid = 0; m_rd = 0; m_age = 0; m_stall = 0;
      end
      pwm  = rw && (rd != 0);
      take = v && !m_valid && (lrd != 0);
      exp_v = {!m_valid, 1'b0, 5'd0, 32'd0, m_stall, m_valid, (m_valid ? m_rd : 5'd0)};
      if (!do_rst) begin
        if (pwm)          exp_v[44:7] = {1'b1, rd, res};
        else if (m_valid) exp_v[44:7] = {1'b1, m_rd, m_data};
        else if (take)    exp_v[44:7] = {1'b1, lrd, ld};
      end
      @(negedge clk);
      act_v = {lu_ready, rf_we, rf_rd, rf_wd, StallReq, pend_valid, pend_rd};
      checks++; if (act_v !== exp_v)
        begin errors++; $display("FAIL random_cycle%0d got %012h want %012h", n, act_v, exp_v); end
      if (!do_rst) begin
        if (m_valid) begin
          if (!pwm || rd == m_rd) begin
            m_valid = 0; m_age = 0; m_stall = 0;
          end else begin
`ifdef WBARB_AGE_LIMIT_EN
            m_age   = (m_age + 1 > AGE_LIMIT) ? AGE_LIMIT : m_age + 1;
            m_stall = (m_age == AGE_LIMIT);
`endif
          end
        end else if (take && pwm) begin
          m_valid = 1; m_rd = lrd; m_data = ld; m_age = 0;
        end
      end
      next_cycle();
    end
    rst = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    next_cycle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_capture();
    test_drop();
    test_lu_rd_zero();
`ifdef WBARB_AGE_LIMIT_EN
    test_aging();
`else
    test_no_stall();
`endif
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
